// File: rtl/block_move_ctrl.sv
// block_move_ctrl: arbitrates player moves and gravity, runs each candidate through the collision checker, then commits, locks or errors.
// Optional BLOCK_MOVE_LOCK_DELAY_EN: the first failed gravity step only arms the lock; the next one locks.
module block_move_ctrl #(
  parameter int GRAVITY_DIV = 25000000,
  parameter int CHK_TIMEOUT = 16,
  parameter int X_MAX = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       mv_rot,
  input  logic       mv_down,
  input  logic [9:0] cur_x,
  input  logic [9:0] cur_y,
  input  logic [9:0] cur_rot,
  output logic [9:0] cand_x,
  output logic [9:0] cand_y,
  output logic [9:0] cand_rot,
  output logic       chk_req,
  input  logic       chk_done,
  input  logic       chk_ok,
  output logic       block_pos_refresh,
  output logic       lock_req,
  output logic       err
);
  localparam int GW = $clog2(GRAVITY_DIV);
  localparam int TW = $clog2(CHK_TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_COMMIT, S_LOCK, S_ERR} state_t;
  typedef enum logic [2:0] {K_DOWN, K_GRAV, K_ROT, K_LEFT, K_RIGHT} kind_t;
  state_t state;
  kind_t kind, pick;
  logic p_left, p_right, p_rot, p_down, p_grav, reject;
  logic any, take, flush, wrap, down_ok, grav_fail, lock_go;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] tcnt;
  always_comb begin
    any = p_down || p_grav || p_rot || p_left || p_right;
    pick = p_down ? K_DOWN : p_grav ? K_GRAV : p_rot ? K_ROT : p_left ? K_LEFT : K_RIGHT;
    take = state == S_IDLE && any;
    flush = state == S_LOCK || state == S_ERR;
    wrap = gcnt == GW'(GRAVITY_DIV - 1);
    down_ok = state == S_WAIT && chk_done && chk_ok && (kind == K_DOWN || kind == K_GRAV);
    grav_fail = state == S_WAIT && chk_done && !chk_ok && kind == K_GRAV;
  end
`ifdef BLOCK_MOVE_LOCK_DELAY_EN
  logic lock_armed;
  always_ff @(posedge clk)
    if (rst || state == S_ERR || state == S_LOCK || down_ok) lock_armed <= 1'b0;
    else if (grav_fail) lock_armed <= 1'b1;
  assign lock_go = lock_armed;
`else
  assign lock_go = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      kind <= K_DOWN;
      {p_left, p_right, p_rot, p_down, p_grav} <= '0;
      gcnt <= '0;
      tcnt <= '0;
      reject <= 1'b0;
      cand_x <= '0;
      cand_y <= '0;
      cand_rot <= '0;
      chk_req <= 1'b0;
      block_pos_refresh <= 1'b0;
      lock_req <= 1'b0;
      err <= 1'b0;
    end else begin
      gcnt <= (wrap || down_ok) ? '0 : gcnt + 1'b1;
      // a pulse arriving in the same cycle as its clear wins, so no request is lost
      p_down <= (p_down && !(take && pick == K_DOWN) && !flush) || mv_down;
      p_grav <= (p_grav && !(take && pick == K_GRAV) && state != S_ERR) || wrap;
      p_rot <= (p_rot && !(take && pick == K_ROT) && !flush) || mv_rot;
      p_left <= (p_left && !(take && pick == K_LEFT) && !flush) || mv_left;
      p_right <= (p_right && !(take && pick == K_RIGHT) && !flush) || mv_right;
      block_pos_refresh <= 1'b0;
      lock_req <= 1'b0;
      err <= 1'b0;
      case (state)
        S_IDLE: if (any) begin
          state <= S_ISSUE;
          kind <= pick;
          cand_x <= pick == K_LEFT ? cur_x - 10'd1 : pick == K_RIGHT ? cur_x + 10'd1 : cur_x;
          cand_y <= (pick == K_DOWN || pick == K_GRAV) ? cur_y + 10'd1 : cur_y;
          cand_rot <= pick == K_ROT ? {8'd0, cur_rot[1:0] + 2'd1} : cur_rot;
          reject <= (pick == K_LEFT && cur_x == 10'd0) || (pick == K_RIGHT && cur_x == 10'(X_MAX));
        end
        S_ISSUE: begin
          tcnt <= '0;
          state <= reject ? S_IDLE : S_WAIT;
          chk_req <= !reject;
        end
        S_WAIT: if (chk_done) begin
          chk_req <= 1'b0;
          state <= chk_ok ? S_COMMIT : (grav_fail && lock_go) ? S_LOCK : S_IDLE;
          block_pos_refresh <= chk_ok;
          lock_req <= grav_fail && lock_go;
        end else if (tcnt == TW'(CHK_TIMEOUT - 1)) begin
          chk_req <= 1'b0;
          state <= S_ERR;
          err <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
